trap_ctrl: RTL and testbench

Machine-mode trap sequencer sitting between interrupt sources, the CSR register file and the fetch/commit stage of the 3-stage core. Latches timer/external interrupt requests, qualifies them against mstatus.MIE and mie, and walks a fixed sequence on the CSR write port: mepc, mcause, mstatus. It then redirects the PC to the mtvec target. Also sequences mret: restores mstatus and redirects to mepc.

---
 rtl/trap_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: latches timer/external interrupts, writes mepc/mcause/mstatus, redirects to mtvec; also sequences mret.
// Optional TRAP_INPUT_SYNC_EN adds 2-flop synchronizers on t_intr_i/e_intr_i.
module trap_ctrl #(
    parameter int DW    = 32,
    parameter int ADDRW = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             t_intr_i,
    input  logic             e_intr_i,
    input  logic             is_mret_i,
    input  logic             commit_valid_i,
    input  logic [DW-1:0]    commit_pc_i,
    input  logic [DW-1:0]    mstatus_i,
    input  logic [DW-1:0]    mie_i,
    input  logic [DW-1:0]    mtvec_i,
    input  logic [DW-1:0]    mepc_i,
    output logic             csr_we_o,
    output logic [ADDRW-1:0] csr_addr_o,
    output logic [DW-1:0]    csr_wdata_o,
    output logic             stall_o,
    output logic             flush_o,
    output logic             redirect_o,
    output logic [DW-1:0]    redirect_pc_o,
    output logic [1:0]       ack_o,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        W_EPC   = 3'd2,
        W_CAUSE = 3'd3,
        W_STAT  = 3'd4,
        JUMP    = 3'd5,
        M_STAT  = 3'd6,
        M_JUMP  = 3'd7
    } state_t;

    localparam logic [ADDRW-1:0] ADDR_MSTATUS = ADDRW'(12'h300);
    localparam logic [ADDRW-1:0] ADDR_MEPC    = ADDRW'(12'h341);
    localparam logic [ADDRW-1:0] ADDR_MCAUSE  = ADDRW'(12'h342);

    state_t        state_r;
    logic          cause_ext_r;
    logic          t_in_s;
    logic          e_in_s;
    logic          t_prev_r;
    logic          e_prev_r;
    logic          p_t_r;
    logic          p_e_r;
    logic          take_s;
    logic          take_ext_s;
    logic [4:0]    cause_code_s;
    logic [DW-1:0] cause_s;
    logic [DW-1:0] trap_stat_s;
    logic [DW-1:0] mret_stat_s;
    logic [DW-1:0] base_s;
    logic [DW-1:0] target_s;
    logic          unused_s;

`ifdef TRAP_INPUT_SYNC_EN
    logic [1:0] t_sync_r;
    logic [1:0] e_sync_r;

    // Two-flop synchronizers for the asynchronous interrupt lines
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            t_sync_r <= 2'b00;
            e_sync_r <= 2'b00;
        end else begin
            t_sync_r <= {t_sync_r[0], t_intr_i};
            e_sync_r <= {e_sync_r[0], e_intr_i};
        end
    end

    assign t_in_s = t_sync_r[1];
    assign e_in_s = e_sync_r[1];
`else
    assign t_in_s = t_intr_i;
    assign e_in_s = e_intr_i;
`endif

    // Rising-edge detect and pending flags; a new edge beats the ack clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            t_prev_r <= 1'b0;
            e_prev_r <= 1'b0;
            p_t_r    <= 1'b0;
            p_e_r    <= 1'b0;
        end else begin
            t_prev_r <= t_in_s;
            e_prev_r <= e_in_s;
            p_t_r    <= (t_in_s & ~t_prev_r) | (p_t_r & ~ack_o[0]);
            p_e_r    <= (e_in_s & ~e_prev_r) | (p_e_r & ~ack_o[1]);
        end
    end

    assign take_ext_s   = mstatus_i[3] & p_e_r & mie_i[11];
    assign take_s       = take_ext_s | (mstatus_i[3] & p_t_r & mie_i[7]);
    assign cause_code_s = cause_ext_r ? 5'd11 : 5'd7;
    assign cause_s      = {1'b1, {(DW-6){1'b0}}, cause_code_s};
    assign base_s       = {mtvec_i[DW-1:2], 2'b00};

    // mstatus images for trap entry (MPIE<=MIE, MIE<=0) and mret (MIE<=MPIE, MPIE<=1)
    always_comb begin
        trap_stat_s    = mstatus_i;
        trap_stat_s[7] = mstatus_i[3];
        trap_stat_s[3] = 1'b0;
        mret_stat_s    = mstatus_i;
        mret_stat_s[3] = mstatus_i[7];
        mret_stat_s[7] = 1'b1;
        if (mtvec_i[1:0] == 2'b01) begin
            target_s = base_s + DW'({cause_code_s, 2'b00});
        end else begin
            target_s = base_s;
        end
    end

    assign unused_s = ^{mie_i[DW-1:12], mie_i[10:8], mie_i[6:0]};

    // Sequencer; outputs are registered alongside the state they belong to
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r       <= IDLE;
            cause_ext_r   <= 1'b0;
            csr_we_o      <= 1'b0;
            csr_addr_o    <= {ADDRW{1'b0}};
            csr_wdata_o   <= {DW{1'b0}};
            stall_o       <= 1'b0;
            flush_o       <= 1'b0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= {DW{1'b0}};
            ack_o         <= 2'b00;
            busy_o        <= 1'b0;
        end else begin
            csr_we_o      <= 1'b0;
            csr_addr_o    <= {ADDRW{1'b0}};
            csr_wdata_o   <= {DW{1'b0}};
            flush_o       <= 1'b0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= {DW{1'b0}};
            ack_o         <= 2'b00;
            stall_o       <= 1'b1;
            busy_o        <= 1'b1;
            case (state_r)
                IDLE: begin
                    if (is_mret_i) begin
                        state_r     <= M_STAT;
                        flush_o     <= 1'b1;
                        csr_we_o    <= 1'b1;
                        csr_addr_o  <= ADDR_MSTATUS;
                        csr_wdata_o <= mret_stat_s;
                    end else if (take_s) begin
                        state_r     <= DRAIN;
                        cause_ext_r <= take_ext_s;
                    end else begin
                        stall_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (commit_valid_i) begin
                        state_r     <= W_EPC;
                        flush_o     <= 1'b1;
                        csr_we_o    <= 1'b1;
                        csr_addr_o  <= ADDR_MEPC;
                        csr_wdata_o <= commit_pc_i;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                W_EPC: begin
                    state_r     <= W_CAUSE;
                    csr_we_o    <= 1'b1;
                    csr_addr_o  <= ADDR_MCAUSE;
                    csr_wdata_o <= cause_s;
                end
                W_CAUSE: begin
                    state_r     <= W_STAT;
                    csr_we_o    <= 1'b1;
                    csr_addr_o  <= ADDR_MSTATUS;
                    csr_wdata_o <= trap_stat_s;
                end
                W_STAT: begin
                    state_r       <= JUMP;
                    redirect_o    <= 1'b1;
                    redirect_pc_o <= target_s;
                    ack_o         <= cause_ext_r ? 2'b10 : 2'b01;
                end
                M_STAT: begin
                    state_r       <= M_JUMP;
                    redirect_o    <= 1'b1;
                    redirect_pc_o <= mepc_i;
                end
                JUMP, M_JUMP: begin
                    state_r <= IDLE;
                    stall_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    stall_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: per-cycle vector table plus hand sequences for vectored priority, reset abort and drain hold.
module tb_trap_ctrl;
    localparam int DW    = 32;
    localparam int ADDRW = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             t_intr, e_intr, is_mret, commit_valid;
    logic [DW-1:0]    commit_pc, mstatus, mie, mtvec, mepc;
    logic             csr_we, stall, flush, redirect, busy;
    logic [ADDRW-1:0] csr_addr;
    logic [DW-1:0]    csr_wdata, redirect_pc;
    logic [1:0]       ack;

    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] rpc;
        logic [1:0]  ack;
        logic        busy;
    } out_t;

    typedef struct {
        string       name;
        logic        t, e, mret, cv;
        logic [31:0] cpc, mst, mie, mtvec, mepc;
        out_t        exp;
    } vec_t;

    out_t act;
    vec_t vecs[$];
    int   checks = 0;
    int   passes = 0;

    assign act = {csr_we, csr_addr, csr_wdata, stall, flush, redirect, redirect_pc, ack, busy};

    always #5 clk = ~clk;

    trap_ctrl #(.DW(DW), .ADDRW(ADDRW)) dut (
        .clk_i(clk), .rst_i(rst), .t_intr_i(t_intr), .e_intr_i(e_intr),
        .is_mret_i(is_mret), .commit_valid_i(commit_valid), .commit_pc_i(commit_pc),
        .mstatus_i(mstatus), .mie_i(mie), .mtvec_i(mtvec), .mepc_i(mepc),
        .csr_we_o(csr_we), .csr_addr_o(csr_addr), .csr_wdata_o(csr_wdata),
        .stall_o(stall), .flush_o(flush), .redirect_o(redirect),
        .redirect_pc_o(redirect_pc), .ack_o(ack), .busy_o(busy)
    );

    function automatic out_t o_busy();
        out_t r = '0;
        r.stall = 1'b1;
        r.busy  = 1'b1;
        return r;
    endfunction

    function automatic out_t o_wr(input logic [11:0] a, input logic [31:0] d, input logic fl);
        out_t r = o_busy();
        r.we    = 1'b1;
        r.addr  = a;
        r.wdata = d;
        r.flush = fl;
        return r;
    endfunction

    function automatic out_t o_jmp(input logic [31:0] pc, input logic [1:0] ak);
        out_t r = o_busy();
        r.redir = 1'b1;
        r.rpc   = pc;
        r.ack   = ak;
        return r;
    endfunction

    task automatic add(input string nm, input logic t, input logic e, input logic mr, input logic cv,
                       input logic [31:0] cpc, input logic [31:0] ms, input logic [31:0] me,
                       input logic [31:0] mt, input logic [31:0] mp, input out_t ex);
        vec_t v;
        v.name = nm; v.t = t; v.e = e; v.mret = mr; v.cv = cv; v.cpc = cpc;
        v.mst = ms; v.mie = me; v.mtvec = mt; v.mepc = mp; v.exp = ex;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, a, e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs until redirect (bounded), mirroring mstatus writes back into mstatus like the CSR file would
    task automatic run_trap(output logic found, output logic [31:0] cause,
                            output logic [31:0] rpc, output logic [1:0] ak);
        found = 1'b0; cause = 32'h0; rpc = 32'h0; ak = 2'b00;
        for (int k = 0; k < 20; k++) begin
            step();
            if (csr_we && csr_addr == 12'h342) cause = csr_wdata;
            if (csr_we && csr_addr == 12'h300) mstatus = csr_wdata;
            if (redirect) begin
                found = 1'b1; rpc = redirect_pc; ak = ack;
                break;
            end
        end
    endtask

    initial begin
        logic        found;
        logic [31:0] cause, rpc;
        logic [1:0]  ak;
        int          bad;

        rst = 1'b1; t_intr = 1'b0; e_intr = 1'b0; is_mret = 1'b0; commit_valid = 1'b0;
        commit_pc = 32'h0; mstatus = 32'h0; mie = 32'h0; mtvec = 32'h0; mepc = 32'h0;

        // Timer, direct mode
        add("t1_pulse", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h8, 32'h80, 32'h100, 32'h0, '0);
        add("t1_take",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h8, 32'h80, 32'h100, 32'h0, o_busy());
        add("t1_epc",   1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h8, 32'h80, 32'h100, 32'h0, o_wr(12'h341, 32'h40, 1'b1));
        add("t1_cause", 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h8, 32'h80, 32'h100, 32'h0, o_wr(12'h342, 32'h80000007, 1'b0));
        add("t1_stat",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h8, 32'h80, 32'h100, 32'h0, o_wr(12'h300, 32'h80, 1'b0));
        add("t1_jump",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h8, 32'h80, 32'h100, 32'h0, o_jmp(32'h100, 2'b01));
        add("t1_idle",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h8, 32'h80, 32'h100, 32'h0, '0);
        add("t1_clear", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h8, 32'h80, 32'h100, 32'h0, '0);
        // mret
        add("mret_stat", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h80, 32'h0, 32'h100, 32'h44, o_wr(12'h300, 32'h88, 1'b1));
        add("mret_jump", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h80, 32'h0, 32'h100, 32'h44, o_jmp(32'h44, 2'b00));
        add("mret_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h80, 32'h0, 32'h100, 32'h44, '0);
        // MIE=0 holds the pending flag until enabled
        add("mie0_pulse",  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0, 32'h80, 32'h100, 32'h0, '0);
        add("mie0_hold1",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0, 32'h80, 32'h100, 32'h0, '0);
        add("mie0_hold2",  1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h0, 32'h80, 32'h100, 32'h0, '0);
        add("mie0_enable", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h8, 32'h80, 32'h100, 32'h0, o_busy());
        add("mie0_epc",    1'b0, 1'b0, 1'b0, 1'b1, 32'h60, 32'h8, 32'h80, 32'h100, 32'h0, o_wr(12'h341, 32'h60, 1'b1));
        add("mie0_cause",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h8, 32'h80, 32'h100, 32'h0, o_wr(12'h342, 32'h80000007, 1'b0));
        add("mie0_stat",   1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h8, 32'h80, 32'h100, 32'h0, o_wr(12'h300, 32'h80, 1'b0));
        add("mie0_jump",   1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h8, 32'h80, 32'h100, 32'h0, o_jmp(32'h100, 2'b01));
        add("mie0_idle",   1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h8, 32'h80, 32'h100, 32'h0, '0);

        step();
        step();
        chk("reset_out", act, 0);
        rst = 1'b0;
        step();
        chk("reset_idle", act, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            t_intr = vecs[i].t; e_intr = vecs[i].e; is_mret = vecs[i].mret;
            commit_valid = vecs[i].cv; commit_pc = vecs[i].cpc; mstatus = vecs[i].mst;
            mie = vecs[i].mie; mtvec = vecs[i].mtvec; mepc = vecs[i].mepc;
            step();
            chk(vecs[i].name, act, vecs[i].exp);
        end

        // Vectored mode, simultaneous sources: external first, timer after MIE is restored
        is_mret = 1'b0; mstatus = 32'h8; mie = 32'h880; mtvec = 32'h201;
        commit_valid = 1'b1; commit_pc = 32'h80;
        t_intr = 1'b1; e_intr = 1'b1;
        step();
        t_intr = 1'b0; e_intr = 1'b0;
        run_trap(found, cause, rpc, ak);
        chk("vec_ext_found", found, 1);
        chk("vec_ext_pc", rpc, 32'h22C);
        chk("vec_ext_ack", ak, 2'b10);
        chk("vec_ext_cause", cause, 32'h8000000B);
        chk("vec_ext_mstatus", mstatus, 32'h80);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (busy) bad++;
        end
        chk("vec_hold_while_mie0", bad, 0);
        mstatus = 32'h8;
        run_trap(found, cause, rpc, ak);
        chk("vec_tmr_found", found, 1);
        chk("vec_tmr_pc", rpc, 32'h21C);
        chk("vec_tmr_ack", ak, 2'b01);
        chk("vec_tmr_cause", cause, 32'h80000007);
        step();
        mstatus = 32'h8;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (busy) bad++;
        end
        chk("vec_both_cleared", bad, 0);

        // Reset during W_CAUSE aborts with no further writes and clears pending
        mie = 32'h80; mtvec = 32'h100; mstatus = 32'h8; commit_valid = 1'b0;
        t_intr = 1'b1;
        step();
        t_intr = 1'b0;
        step();
        commit_valid = 1'b1; commit_pc = 32'h70;
        step();
        commit_valid = 1'b0;
        step();
        chk("rst_pre_cause", {csr_we, csr_addr}, {1'b1, 12'h342});
        rst = 1'b1;
        #1;
        chk("rst_async_out", act, 0);
        step();
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (csr_we || busy || redirect) bad++;
        end
        chk("rst_quiet", bad, 0);

        // Drain holds with stall and no writes until commit_valid rises
        t_intr = 1'b1;
        step();
        t_intr = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("drain_hold%0d", k), {stall, csr_we, flush}, 3'b100);
        end
        commit_valid = 1'b1; commit_pc = 32'h88;
        step();
        commit_valid = 1'b0;
        chk("drain_epc", {csr_we, csr_addr, csr_wdata, flush}, {1'b1, 12'h342 - 12'h1, 32'h88, 1'b1});
        run_trap(found, cause, rpc, ak);
        chk("drain_redirect", {found, rpc, ak}, {1'b1, 32'h100, 2'b01});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
